// File: rtl/shf_barrel_pipe_if.sv
// shf_barrel_pipe_if: input/output handshake bundle of the pipelined barrel shifter.
// The master drives operands and downstream ready; the slave (the shifter) returns results.
interface shf_barrel_pipe_if #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_SHIFT = 5,
  parameter int SIZE_TAG   = 4
);
  logic                  i_valid;
  logic                  o_ready;
  logic [SIZE_DATA-1:0]  i_data;
  logic [SIZE_SHIFT-1:0] i_shift_number;
  logic [1:0]            i_mode;
  logic [SIZE_TAG-1:0]   i_tag;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [SIZE_DATA-1:0]  o_data;
  logic                  o_sticky;
  logic [SIZE_TAG-1:0]   o_tag;
  modport master (
    output i_valid, i_data, i_shift_number, i_mode, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_sticky, o_tag
  );
  modport slave (
    input  i_valid, i_data, i_shift_number, i_mode, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_sticky, o_tag
  );
endinterface

// File: rtl/shf_barrel_pipe.sv
// shf_barrel_pipe: log-stage barrel shifter (lsr/asr/lsl/ror) with sticky output,
// a register after every REG_EVERY stages plus the last, and valid/ready backpressure.
module shf_barrel_pipe #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_SHIFT = 5,
  parameter int REG_EVERY  = 2,
  parameter int SIZE_TAG   = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  shf_barrel_pipe_if.slave bus
);
  localparam int N = SIZE_DATA;
  localparam int L = (SIZE_SHIFT + REG_EVERY - 1) / REG_EVERY;
  typedef struct packed {
    logic                  v;
    logic [N-1:0]          d;
    logic                  s;
    logic [1:0]            m;
    logic [SIZE_SHIFT-1:0] sh;
    logic [SIZE_TAG-1:0]   t;
  } st_t;
  function automatic int rot_amt(int k);
    int r = 1 % N;
    for (int i = 0; i < k; i++) r = (r * 2) % N;
    return r;
  endfunction
  function automatic int last_stage(int j);
    return ((j + 1) * REG_EVERY < SIZE_SHIFT ? (j + 1) * REG_EVERY : SIZE_SHIFT) - 1;
  endfunction
  st_t  in_st;
  st_t  x [SIZE_SHIFT];
  st_t  y [SIZE_SHIFT];
  st_t  r_d [L];
  st_t  r_q [L];
  logic stall;
  assign stall        = r_q[L-1].v & ~bus.i_ready;
  assign bus.o_ready  = ~stall;
  assign bus.o_valid  = r_q[L-1].v;
  assign bus.o_data   = r_q[L-1].d;
  assign bus.o_sticky = r_q[L-1].s;
  assign bus.o_tag    = r_q[L-1].t;
  always_comb begin
    in_st.v  = bus.i_valid & ~stall;
    in_st.d  = bus.i_data;
    in_st.s  = 1'b0;
    in_st.m  = bus.i_mode;
    in_st.sh = bus.i_shift_number;
    in_st.t  = bus.i_tag;
  end
  for (genvar k = 0; k < SIZE_SHIFT; k++) begin : g_stage
    localparam int A = k < 30 ? 1 << k : N;
    localparam int R = rot_amt(k);
    localparam logic [N-1:0] ONES = '1;
    st_t xs, ys;
    logic [N-1:0] asr;
    if (k == 0) begin : g_in
      assign xs = in_st;
    end else if (k % REG_EVERY == 0) begin : g_reg
      assign xs = r_q[k/REG_EVERY-1];
    end else begin : g_comb
      assign xs = y[k-1];
    end
    assign x[k] = xs;
    assign y[k] = ys;
    // Shifts of A >= N fall out naturally: zeros, all-sign, and a full-operand sticky mask.
    assign asr = $signed(xs.d) >>> A;
    always_comb begin
      ys = xs;
      if (xs.sh[k]) begin
        ys.d = xs.m == 2'b11 ? (xs.d >> R) | (xs.d << (N - R)) :
               xs.m == 2'b10 ? xs.d << A :
               xs.m == 2'b01 ? asr : xs.d >> A;
        ys.s = xs.s | (xs.m == 2'b11 ? 1'b0 :
                       xs.m == 2'b10 ? |(xs.d & ~(ONES >> A)) : |(xs.d & ~(ONES << A)));
      end
    end
  end
  always_comb begin
    for (int j = 0; j < L; j++) r_d[j] = y[last_stage(j)];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < L; j++) r_q[j] <= '0;
    end else if (bus.i_flush) begin
      for (int j = 0; j < L; j++) r_q[j].v <= 1'b0;
    end else if (!stall) begin
      for (int j = 0; j < L; j++) r_q[j] <= r_d[j];
    end
  end
endmodule

// File: tb/tb_shf_barrel_pipe.sv
// tb_shf_barrel_pipe: directed scenario tasks for the pipelined barrel shifter,
// a 32-bit default instance plus a 24-bit instance for non-power-of-two widths.
module tb_shf_barrel_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  shf_barrel_pipe_if #(.SIZE_DATA(32), .SIZE_SHIFT(5), .SIZE_TAG(4)) b32 ();
  shf_barrel_pipe_if #(.SIZE_DATA(24), .SIZE_SHIFT(5), .SIZE_TAG(4)) b24 ();

  shf_barrel_pipe #(.SIZE_DATA(32), .SIZE_SHIFT(5), .REG_EVERY(2), .SIZE_TAG(4)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b32)
  );
  shf_barrel_pipe #(.SIZE_DATA(24), .SIZE_SHIFT(5), .REG_EVERY(2), .SIZE_TAG(4)) dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b24)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] m, input logic [3:0] t);
    b32.i_valid = v;
    b32.i_data = d;
    b32.i_shift_number = sh;
    b32.i_mode = m;
    b32.i_tag = t;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0);
    b32.i_flush = 0; b32.i_ready = 1;
    b24.i_valid = 0; b24.i_data = 0; b24.i_shift_number = 0; b24.i_mode = 0; b24.i_tag = 0;
    b24.i_flush = 0; b24.i_ready = 1;
    rst_n = 0;
    tick; tick;
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", b32.o_valid); end
    checks++; if (b32.o_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", b32.o_data); end
    checks++; if (b32.o_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", b32.o_sticky); end
    checks++; if (b32.o_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got=%h exp=0", b32.o_tag); end
    checks++; if (b24.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid24 got=%b exp=0", b24.o_valid); end
    rst_n = 1;
    #1;
    checks++; if (b32.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", b32.o_ready); end
    tick;
  endtask

  task automatic test_basic;
    drive(1, 32'h8000_0010, 4, 2'b00, 4'h1);
    tick;
    drive(0, 0, 0, 0, 0);
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got=%b exp=0", b32.o_valid); end
    tick;
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2 got=%b exp=0", b32.o_valid); end
    tick;
    checks++; if (b32.o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", b32.o_valid); end
    checks++; if (b32.o_data !== 32'h0800_0001) begin errors++; $display("FAIL basic_data got=%h exp=08000001", b32.o_data); end
    checks++; if (b32.o_sticky !== 1'b0) begin errors++; $display("FAIL basic_sticky got=%b exp=0", b32.o_sticky); end
    checks++; if (b32.o_tag !== 4'h1) begin errors++; $display("FAIL basic_tag got=%h exp=1", b32.o_tag); end
    tick;
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL basic_single got=%b exp=0", b32.o_valid); end
  endtask

  task automatic test_modes;
    logic [31:0] ed [4] = '{32'h0780_0000, 32'hFF00_0000, 32'h0000_00F0, 32'hFF00_0000};
    logic        es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0) ? 32'h7800_000F : 32'hF000_000F, 4, 2'(i), 4'(i + 2));
      tick;
      drive(0, 0, 0, 0, 0);
      tick; tick;
      checks++; if (b32.o_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got=%b exp=1", i, b32.o_valid); end
      checks++; if (b32.o_data !== ed[i]) begin errors++; $display("FAIL mode%0d_data got=%h exp=%h", i, b32.o_data, ed[i]); end
      checks++; if (b32.o_sticky !== es[i]) begin errors++; $display("FAIL mode%0d_sticky got=%b exp=%b", i, b32.o_sticky, es[i]); end
      checks++; if (b32.o_tag !== 4'(i + 2)) begin errors++; $display("FAIL mode%0d_tag got=%h exp=%h", i, b32.o_tag, 4'(i + 2)); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    int first = -1;
    bit gap = 0;
    for (int t = 0; t < 14; t++) begin
      if (t < 8) drive(1, 32'hFFFF_FFFF, 5'(t), 2'b00, 4'(t));
      else drive(0, 0, 0, 0, 0);
      tick;
      if (b32.o_valid === 1'b1) begin
        if (first < 0) first = t;
        if (t != first + got) gap = 1;
        if (got < 8) begin
          checks++; if (b32.o_data !== (32'hFFFF_FFFF >> got)) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", got, b32.o_data, 32'hFFFF_FFFF >> got); end
          checks++; if (b32.o_sticky !== (got != 0)) begin errors++; $display("FAIL b2b_sticky%0d got=%b exp=%b", got, b32.o_sticky, got != 0); end
          checks++; if (b32.o_tag !== 4'(got)) begin errors++; $display("FAIL b2b_tag%0d got=%h exp=%h", got, b32.o_tag, 4'(got)); end
        end
        got++;
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
    checks++; if (gap) begin errors++; $display("FAIL b2b_gap got=1 exp=0"); end
    checks++; if (first != 2) begin errors++; $display("FAIL b2b_first got=%0d exp=2", first); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ed [3] = '{32'h1234_5678, 32'h0123_4567, 32'h0000_1234};
    logic [4:0]  sh [3] = '{5'd0, 5'd4, 5'd16};
    logic        es [3] = '{1'b0, 1'b1, 1'b1};
    int acc = 0;
    int got = 0;
    b32.i_ready = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, 32'h1234_5678, sh[acc < 3 ? acc : 2], 2'b00, 4'(8 + acc));
      #1;
      if (b32.o_ready) acc++;
      tick;
      if (!b32.o_ready) break;
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
    drive(1, 32'hDEAD_BEEF, 1, 2'b00, 4'hF);
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++; if (b32.o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0", c, b32.o_ready); end
      checks++; if (b32.o_valid !== 1'b1 || b32.o_data !== ed[0] || b32.o_tag !== 4'h8) begin errors++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/%h/8", c, b32.o_valid, b32.o_data, b32.o_tag, ed[0]); end
    end
    drive(0, 0, 0, 0, 0);
    b32.i_ready = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (b32.o_valid === 1'b1) begin
        if (got < 3) begin
          checks++; if (b32.o_data !== ed[got]) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", got, b32.o_data, ed[got]); end
          checks++; if (b32.o_sticky !== es[got]) begin errors++; $display("FAIL bp_sticky%0d got=%b exp=%b", got, b32.o_sticky, es[got]); end
          checks++; if (b32.o_tag !== 4'(8 + got)) begin errors++; $display("FAIL bp_tag%0d got=%h exp=%h", got, b32.o_tag, 4'(8 + got)); end
        end
        got++;
      end
      tick;
    end
    checks++; if (got != 3) begin errors++; $display("FAIL bp_drained got=%0d exp=3", got); end
  endtask

  task automatic test_oversize;
    logic [23:0] ed [3] = '{24'h00_0000, 24'hFF_FFFF, 24'h03_0000};
    logic [1:0]  md [3] = '{2'b00, 2'b01, 2'b11};
    logic        es [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      b24.i_valid = 1; b24.i_data = 24'h80_0001; b24.i_shift_number = 5'd31;
      b24.i_mode = md[i]; b24.i_tag = 4'(i);
      tick;
      b24.i_valid = 0;
      tick; tick;
      checks++; if (b24.o_valid !== 1'b1) begin errors++; $display("FAIL over%0d_valid got=%b exp=1", i, b24.o_valid); end
      checks++; if (b24.o_data !== ed[i]) begin errors++; $display("FAIL over%0d_data got=%h exp=%h", i, b24.o_data, ed[i]); end
      checks++; if (b24.o_sticky !== es[i]) begin errors++; $display("FAIL over%0d_sticky got=%b exp=%b", i, b24.o_sticky, es[i]); end
      tick;
    end
  endtask

  task automatic test_flush_reset;
    drive(1, 32'hAAAA_0001, 1, 2'b00, 4'h1); tick;
    drive(1, 32'hAAAA_0002, 2, 2'b00, 4'h2); tick;
    drive(1, 32'hAAAA_0003, 3, 2'b00, 4'h3);
    b32.i_flush = 1;
    tick;
    b32.i_flush = 0;
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid%0d got=%b exp=0", c, b32.o_valid); end
      tick;
    end
    b32.i_ready = 0;
    drive(1, 32'h5555_0000, 0, 2'b00, 4'h4); tick;
    drive(0, 0, 0, 0, 0); tick; tick;
    checks++; if (b32.o_valid !== 1'b1 || b32.o_ready !== 1'b0) begin errors++; $display("FAIL flush_stallsetup got=%b/%b exp=1/0", b32.o_valid, b32.o_ready); end
    b32.i_flush = 1;
    tick;
    b32.i_flush = 0;
    checks++; if (b32.o_valid !== 1'b0 || b32.o_ready !== 1'b1) begin errors++; $display("FAIL flush_overstall got=%b/%b exp=0/1", b32.o_valid, b32.o_ready); end
    b32.i_ready = 1;
    drive(1, 32'hBBBB_0001, 1, 2'b00, 4'h5); tick;
    drive(1, 32'hBBBB_0002, 2, 2'b00, 4'h6); tick;
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    checks++; if (b32.o_valid !== 1'b0 || b32.o_data !== 32'h0) begin errors++; $display("FAIL rst_async got=%b/%h exp=0/0", b32.o_valid, b32.o_data); end
    tick;
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid%0d got=%b exp=0", c, b32.o_valid); end
    end
    drive(1, 32'h0000_0F00, 8, 2'b00, 4'h7);
    tick;
    drive(0, 0, 0, 0, 0);
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL post_lat1 got=%b exp=0", b32.o_valid); end
    tick;
    checks++; if (b32.o_valid !== 1'b0) begin errors++; $display("FAIL post_lat2 got=%b exp=0", b32.o_valid); end
    tick;
    checks++; if (b32.o_valid !== 1'b1) begin errors++; $display("FAIL post_valid got=%b exp=1", b32.o_valid); end
    checks++; if (b32.o_data !== 32'h0000_000F) begin errors++; $display("FAIL post_data got=%h exp=0000000f", b32.o_data); end
    checks++; if (b32.o_sticky !== 1'b0 || b32.o_tag !== 4'h7) begin errors++; $display("FAIL post_sticky_tag got=%b/%h exp=0/7", b32.o_sticky, b32.o_tag); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_modes;
    test_back_to_back;
    test_backpressure;
    test_oversize;
    test_flush_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
